// File: rtl/overlay_screen_ctrl.sv
// Game screen sequencer and text-overlay compositor: a frame-tick driven state machine
// selects the screen, and a fixed box is blended into the delayed video stream.
module overlay_screen_ctrl #(
    parameter int          CW           = 16,
    parameter int          RECT_X       = 380,
    parameter int          RECT_Y       = 450,
    parameter int          RECT_W       = 264,
    parameter int          RECT_H       = 100,
    parameter int          FONT_LAT     = 1,
    parameter int          BLINK_FRAMES = 30,
    parameter bit          BLINK_EN     = 1'b1,
    parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter int          BG_MODE      = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] hcount_in,
    input  logic [CW-1:0] vcount_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [11:0]   rgb_in,
    input  logic          game_start,
    input  logic          pause_toggle,
    input  logic          game_over,
    input  logic          font_bit,
    output logic [7:0]    char_col,
    output logic [3:0]    char_row,
    output logic [3:0]    char_line,
    output logic [1:0]    screen_id,
    output logic [CW-1:0] hcount_out,
    output logic [CW-1:0] vcount_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic [11:0]   rgb_out,
    output logic          overlay_active
);

    typedef enum logic [1:0] {
        INTRO     = 2'd0,
        PLAYING   = 2'd1,
        PAUSED    = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam int unsigned D      = FONT_LAT + 1;
    localparam logic [CW:0] X_LO   = (CW+1)'(RECT_X);
    localparam logic [CW:0] X_HI   = (CW+1)'(RECT_X + RECT_W);
    localparam logic [CW:0] Y_LO   = (CW+1)'(RECT_Y);
    localparam logic [CW:0] Y_HI   = (CW+1)'(RECT_Y + RECT_H);
    localparam logic [15:0] BF_MAX = 16'(BLINK_FRAMES - 1);

    state_t      state_q, state_d;
    logic        pend_start_q, pend_pause_q, pend_over_q;
    logic        vs_prev_q;
    logic [15:0] blink_cnt_q;
    logic        blink_phase_q;
    logic        frame_tick;

    assign frame_tick = vsync_in & ~vs_prev_q;
    assign screen_id  = state_q;

    // Only the highest-priority pending event is considered; the others are dropped.
    always_comb begin
        state_d = state_q;
        if (pend_over_q) begin
            if (state_q == PLAYING || state_q == PAUSED) state_d = GAME_OVER;
        end else if (pend_pause_q) begin
            if (state_q == PLAYING)     state_d = PAUSED;
            else if (state_q == PAUSED) state_d = PLAYING;
        end else if (pend_start_q) begin
            if (state_q == INTRO || state_q == GAME_OVER) state_d = PLAYING;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INTRO;
            pend_start_q  <= 1'b0;
            pend_pause_q  <= 1'b0;
            pend_over_q   <= 1'b0;
            vs_prev_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else begin
            vs_prev_q <= vsync_in;
            if (frame_tick) begin
                state_q      <= state_d;
                // Pulses arriving on the tick cycle seed the next frame's flags.
                pend_start_q <= game_start;
                pend_pause_q <= pause_toggle;
                pend_over_q  <= game_over;
                if (state_d != state_q) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= 1'b1;
                end else if (blink_cnt_q == BF_MAX) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 16'd1;
                end
            end else begin
                pend_start_q <= pend_start_q | game_start;
                pend_pause_q <= pend_pause_q | pause_toggle;
                pend_over_q  <= pend_over_q  | game_over;
            end
        end
    end

    logic [CW:0]   hx, vy;
    logic [CW-1:0] relx, rely;
    logic          in_box;

    always_comb begin
        hx     = {1'b0, hcount_in};
        vy     = {1'b0, vcount_in};
        in_box = (hx >= X_LO) && (hx < X_HI) && (vy >= Y_LO) && (vy < Y_HI);
        relx   = hcount_in - CW'(RECT_X);
        rely   = vcount_in - CW'(RECT_Y);
    end

    logic [CW-1:0] hc_q [D];
    logic [CW-1:0] vc_q [D];
    logic          hs_q [D];
    logic          vs_q [D];
    logic [11:0]   rgb_q [D];
    logic          box_q [D];
    logic          show_text, act_d;
    logic [11:0]   rgb_d;

    // Stage D-1 lines up with font_bit for the char address issued at stage 0.
    always_comb begin
        show_text = (state_q == INTRO) ? 1'b1 : (BLINK_EN ? blink_phase_q : 1'b1);
        act_d     = box_q[D-1] && (state_q != PLAYING);
        rgb_d     = rgb_q[D-1];
        if (act_d) begin
            if (show_text && font_bit) begin
                rgb_d = TEXT_COLOR;
            end else begin
                case (BG_MODE)
                    1:       rgb_d = BG_COLOR;
                    2:       rgb_d = {1'b0, rgb_q[D-1][11:9], 1'b0, rgb_q[D-1][7:5],
                                      1'b0, rgb_q[D-1][3:1]};
                    default: rgb_d = rgb_q[D-1];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < D; i++) begin
                hc_q[i]  <= '0;
                vc_q[i]  <= '0;
                hs_q[i]  <= 1'b0;
                vs_q[i]  <= 1'b0;
                rgb_q[i] <= '0;
                box_q[i] <= 1'b0;
            end
            char_col       <= '0;
            char_row       <= '0;
            char_line      <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            hsync_out      <= 1'b0;
            vsync_out      <= 1'b0;
            rgb_out        <= '0;
            overlay_active <= 1'b0;
        end else begin
            hc_q[0]  <= hcount_in;
            vc_q[0]  <= vcount_in;
            hs_q[0]  <= hsync_in;
            vs_q[0]  <= vsync_in;
            rgb_q[0] <= rgb_in;
            box_q[0] <= in_box;
            for (int unsigned i = 1; i < D; i++) begin
                hc_q[i]  <= hc_q[i-1];
                vc_q[i]  <= vc_q[i-1];
                hs_q[i]  <= hs_q[i-1];
                vs_q[i]  <= vs_q[i-1];
                rgb_q[i] <= rgb_q[i-1];
                box_q[i] <= box_q[i-1];
            end
            char_col       <= in_box ? 8'(relx >> 3) : '0;
            char_row       <= in_box ? 4'(rely >> 4) : '0;
            char_line      <= in_box ? rely[3:0] : '0;
            hcount_out     <= hc_q[D-1];
            vcount_out     <= vc_q[D-1];
            hsync_out      <= hs_q[D-1];
            vsync_out      <= vs_q[D-1];
            rgb_out        <= rgb_d;
            overlay_active <= act_d;
        end
    end

endmodule

// File: tb/tb_overlay_screen_ctrl.sv
// Directed bench for overlay_screen_ctrl: screen sequencing, blink timing,
// background modes, box edges and output latency with hand-computed expectations.
module tb_overlay_screen_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] hcount_in, vcount_in;
    logic          hsync_in, vsync_in;
    logic [11:0]   rgb_in;
    logic          game_start, pause_toggle, game_over, font_bit;

    logic [7:0]    char_col;
    logic [3:0]    char_row, char_line;
    logic [1:0]    screen_id;
    logic [CW-1:0] hcount_out, vcount_out;
    logic          hsync_out, vsync_out;
    logic [11:0]   rgb_out;
    logic          overlay_active;

    logic [7:0]    d2_char_col;
    logic [3:0]    d2_char_row, d2_char_line;
    logic [1:0]    d2_screen_id;
    logic [CW-1:0] d2_hcount_out, d2_vcount_out;
    logic          d2_hsync_out, d2_vsync_out;
    logic [11:0]   rgb_out_dim;
    logic          d2_overlay_active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    overlay_screen_ctrl #(.CW(CW), .BLINK_FRAMES(2), .BG_MODE(1)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .game_start(game_start), .pause_toggle(pause_toggle), .game_over(game_over),
        .font_bit(font_bit), .char_col(char_col), .char_row(char_row),
        .char_line(char_line), .screen_id(screen_id), .hcount_out(hcount_out),
        .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .rgb_out(rgb_out), .overlay_active(overlay_active)
    );

    overlay_screen_ctrl #(.CW(CW), .BLINK_FRAMES(2), .BG_MODE(2)) dut_dim (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .game_start(game_start), .pause_toggle(pause_toggle), .game_over(game_over),
        .font_bit(font_bit), .char_col(d2_char_col), .char_row(d2_char_row),
        .char_line(d2_char_line), .screen_id(d2_screen_id), .hcount_out(d2_hcount_out),
        .vcount_out(d2_vcount_out), .hsync_out(d2_hsync_out), .vsync_out(d2_vsync_out),
        .rgb_out(rgb_out_dim), .overlay_active(d2_overlay_active)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_tick();
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse(input int which);
        if (which == 0) game_start = 1'b1;
        else if (which == 1) pause_toggle = 1'b1;
        else game_over = 1'b1;
        @(negedge clk);
        game_start = 1'b0; pause_toggle = 1'b0; game_over = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        rgb_in = '0; game_start = 1'b0; pause_toggle = 1'b0; game_over = 1'b0;
        font_bit = 1'b0;
        cycles(2);
        rst = 1'b1;
        hcount_in = 16'd400; vcount_in = 16'd460; font_bit = 1'b1;
        rgb_in = 12'h123; hsync_in = 1'b1;
        cycles(3);
        n_checks++; if (rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL intro_text rgb_out got %h expected fff", rgb_out); end
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL intro_screen screen_id got %0d expected 0", screen_id); end
        n_checks++; if (overlay_active !== 1'b1) begin n_fail++; $display("FAIL intro_active overlay_active got %b expected 1", overlay_active); end
        n_checks++; if ({char_col, char_row, char_line} !== {8'd2, 4'd0, 4'd10}) begin n_fail++; $display("FAIL char_addr got col %0d row %0d line %0d expected 2 0 10", char_col, char_row, char_line); end
        rst = 1'b0;
        #1;
        n_checks++; if ({rgb_out, hcount_out, overlay_active, char_col, hsync_out} !== '0) begin n_fail++; $display("FAIL async_reset outputs rgb %h hc %0d act %b col %0d hs %b expected all 0", rgb_out, hcount_out, overlay_active, char_col, hsync_out); end
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL async_reset screen_id got %0d expected 0", screen_id); end
        @(negedge clk);
        rst = 1'b1;
        cycles(3);
    endtask

    task automatic test_latency();
        hcount_in = 16'd401; hsync_in = 1'b0;
        cycles(2);
        n_checks++; if (hcount_out !== 16'd400 || hsync_out !== 1'b1) begin n_fail++; $display("FAIL latency_early hc %0d hs %b expected 400 1", hcount_out, hsync_out); end
        cycles(1);
        n_checks++; if (hcount_out !== 16'd401 || hsync_out !== 1'b0) begin n_fail++; $display("FAIL latency_L hc %0d hs %b expected 401 0", hcount_out, hsync_out); end
    endtask

    task automatic test_bg_modes();
        hcount_in = 16'd400; vcount_in = 16'd460; rgb_in = 12'hEA6; font_bit = 1'b0;
        cycles(3);
        n_checks++; if (rgb_out_dim !== 12'h753) begin n_fail++; $display("FAIL bg_dim rgb_out got %h expected 753", rgb_out_dim); end
        n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL bg_opaque rgb_out got %h expected 000", rgb_out); end
        font_bit = 1'b1;
        cycles(1);
        n_checks++; if (rgb_out_dim !== 12'hFFF) begin n_fail++; $display("FAIL dim_text rgb_out got %h expected fff", rgb_out_dim); end
    endtask

    task automatic test_box_edges();
        rgb_in = 12'hABC; font_bit = 1'b1;
        hcount_in = 16'd644; vcount_in = 16'd460;
        cycles(1);
        n_checks++; if (char_col !== 8'd0) begin n_fail++; $display("FAIL right_edge char_col got %0d expected 0", char_col); end
        cycles(2);
        n_checks++; if (overlay_active !== 1'b0 || rgb_out !== 12'hABC) begin n_fail++; $display("FAIL right_edge act %b rgb %h expected 0 abc", overlay_active, rgb_out); end
        hcount_in = 16'd643;
        cycles(1);
        n_checks++; if (char_col !== 8'd32) begin n_fail++; $display("FAIL last_col char_col got %0d expected 32", char_col); end
        hcount_in = 16'd380; vcount_in = 16'd549;
        cycles(1);
        n_checks++; if ({char_col, char_row, char_line} !== {8'd0, 4'd6, 4'd3}) begin n_fail++; $display("FAIL left_edge col %0d row %0d line %0d expected 0 6 3", char_col, char_row, char_line); end
        cycles(2);
        n_checks++; if (overlay_active !== 1'b1 || rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL left_edge act %b rgb %h expected 1 fff", overlay_active, rgb_out); end
        hcount_in = 16'd400; vcount_in = 16'd449;
        cycles(3);
        n_checks++; if (overlay_active !== 1'b0 || rgb_out !== 12'hABC || char_row !== 4'd0) begin n_fail++; $display("FAIL above_box act %b rgb %h row %0d expected 0 abc 0", overlay_active, rgb_out, char_row); end
        vcount_in = 16'd460;
    endtask

    task automatic test_intro_holds();
        pulse(1); frame_tick();
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL intro_pause screen_id got %0d expected 0", screen_id); end
        pulse(2); frame_tick();
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL intro_over screen_id got %0d expected 0", screen_id); end
    endtask

    task automatic test_reset_midframe();
        pulse(0); cycles(2);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        frame_tick();
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL reset_discard screen_id got %0d expected 0", screen_id); end
    endtask

    task automatic test_start_midframe();
        pulse(0); cycles(4);
        n_checks++; if (screen_id !== 2'd0) begin n_fail++; $display("FAIL start_wait screen_id got %0d expected 0", screen_id); end
        frame_tick();
        n_checks++; if (screen_id !== 2'd1) begin n_fail++; $display("FAIL start_tick screen_id got %0d expected 1", screen_id); end
    endtask

    task automatic test_playing_passthrough();
        logic [11:0] hist [8];
        int errs;
        errs = 0;
        hcount_in = 16'd400; vcount_in = 16'd460; font_bit = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k >= 3 && (rgb_out !== hist[k-3] || overlay_active !== 1'b0)) errs++;
            hist[k] = 12'h100 + 12'(k * 37);
            rgb_in = hist[k];
            @(negedge clk);
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL playing_passthrough %0d cycles differ, expected 0", errs); end
        hcount_in = 16'd10;
        cycles(3);
        n_checks++; if (rgb_out !== hist[7]) begin n_fail++; $display("FAIL playing_outside rgb got %h expected %h", rgb_out, hist[7]); end
        hcount_in = 16'd400;
    endtask

    task automatic test_priority();
        pulse(2); cycles(1); pulse(1);
        frame_tick();
        n_checks++; if (screen_id !== 2'd3) begin n_fail++; $display("FAIL priority screen_id got %0d expected 3", screen_id); end
        frame_tick();
        n_checks++; if (screen_id !== 2'd3) begin n_fail++; $display("FAIL pause_discarded screen_id got %0d expected 3", screen_id); end
    endtask

    task automatic test_restart();
        pulse(0); frame_tick();
        n_checks++; if (screen_id !== 2'd1) begin n_fail++; $display("FAIL restart screen_id got %0d expected 1", screen_id); end
    endtask

    task automatic test_coincident();
        vsync_in = 1'b1; pause_toggle = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0; pause_toggle = 1'b0;
        @(negedge clk);
        n_checks++; if (screen_id !== 2'd1) begin n_fail++; $display("FAIL coincident_now screen_id got %0d expected 1", screen_id); end
        frame_tick();
        n_checks++; if (screen_id !== 2'd2) begin n_fail++; $display("FAIL coincident_next screen_id got %0d expected 2", screen_id); end
    endtask

    task automatic test_blink();
        logic [11:0] exp_rgb, exp_dim;
        rgb_in = 12'h5A5; font_bit = 1'b1;
        cycles(3);
        n_checks++; if (rgb_out !== 12'hFFF || overlay_active !== 1'b1) begin n_fail++; $display("FAIL blink_f0 rgb %h act %b expected fff 1", rgb_out, overlay_active); end
        for (int f = 1; f <= 5; f++) begin
            frame_tick(); cycles(3);
            exp_rgb = (f == 2 || f == 3) ? 12'h000 : 12'hFFF;
            exp_dim = (f == 2 || f == 3) ? 12'h252 : 12'hFFF;
            n_checks++; if (rgb_out !== exp_rgb || rgb_out_dim !== exp_dim) begin n_fail++; $display("FAIL blink_f%0d rgb %h dim %h expected %h %h", f, rgb_out, rgb_out_dim, exp_rgb, exp_dim); end
        end
    endtask

    task automatic test_paused_to_over();
        pulse(2); frame_tick(); cycles(3);
        n_checks++; if (screen_id !== 2'd3) begin n_fail++; $display("FAIL paused_over screen_id got %0d expected 3", screen_id); end
        n_checks++; if (rgb_out !== 12'hFFF) begin n_fail++; $display("FAIL blink_restart rgb %h expected fff", rgb_out); end
        pulse(1); frame_tick();
        n_checks++; if (screen_id !== 2'd3) begin n_fail++; $display("FAIL over_pause screen_id got %0d expected 3", screen_id); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bg_modes();
        test_box_edges();
        test_intro_holds();
        test_reset_midframe();
        test_start_midframe();
        test_playing_passthrough();
        test_priority();
        test_restart();
        test_coincident();
        test_blink();
        test_paused_to_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
